dmem_ws_ctrl: RTL and testbench
===============================

// Module: dmem_ws_ctrl
// PURPOSE
//  Parametrised M-stage data memory with req/ack handshake, programmable wait states, byte/half/word
//  loads and stores with sign/zero extension, and alignment/range fault reporting. Clears memory after reset.
//  Drives a stall (busy) into the pipeline hazard unit. Uses kill to cancel accesses squashed by CP0 interrupt/exception.
// PARAMETERS
//  ADDR_BASE       32'h0000_0000  byte address of word 0
//  DEPTH_WORDS     2048           memory depth in 32-bit words, power of two
//  WAIT_CYCLES     1              extra cycles per access, 0..15
//  CLEAR_ON_RESET  1              1: zero every word after reset, one word per cycle; 0: skip clear
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   reset, synchronous, active-high
//  req        in   1   access request; held high by M stage until ack
//  we         in   1   1 = store, 0 = load
//  size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  sign_ext   in   1   loads only: 1 sign-extend (lb/lh), 0 zero-extend (lbu/lhu)
//  addr       in   32  byte address
//  wdata      in   32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
//  kill       in   1   cancel current/pending access (CP0 IntReq or flush)
//  busy       out  1   stall request to pipeline
//  ack        out  1   one-cycle completion pulse
//  fault      out  1   valid with ack: misaligned, out of range, or illegal size
//  rdata      out  32  extended load data, valid with ack
//  init_done  out  1   high once post-reset clear is finished
// BEHAVIOUR
//  Reset values: ack=0, fault=0, rdata=0, init_done=0.
//  Reset state: CLEAR if CLEAR_ON_RESET=1, else IDLE with init_done=1 on the next cycle.
//  FSM states: CLEAR, IDLE, WAIT, RESP.
//  - CLEAR: write 0 to word clr_idx, 0..DEPTH_WORDS-1, one word per cycle. Ignore req.
//    After the last word, go to IDLE and set init_done=1.
//  - IDLE with req & ~kill: latch addr, size, we, wdata, sign_ext.
//    Compute fault = size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0)
//                    | (addr-ADDR_BASE) >= DEPTH_WORDS*4.
//    Go to WAIT with cnt=WAIT_CYCLES, or straight to RESP if WAIT_CYCLES=0.
//  - IDLE with req & kill: no access; stay in IDLE.
//  - WAIT: decrement cnt each cycle; on the cycle cnt reaches 1, go to RESP.
//    If kill is seen in WAIT: return to IDLE, no write, no ack.
//  - Array access happens on the edge entering RESP, and only if ~fault.
//    Store: byte-merge via BE.
//    Load: read the word, extract, extend, and register into rdata.
//  - RESP: ack=1 for exactly one cycle; fault=latched fault; then go to IDLE.
//    Ignore req in RESP; the pipeline advances at the end of that cycle.
//  busy = CLEAR | WAIT | (IDLE & req & ~kill). busy=0 in RESP.
//  Latency: req accepted in cycle T -> ack in cycle T+1+WAIT_CYCLES.
//  Word index: (addr-ADDR_BASE)[log2(DEPTH_WORDS)+1:2]. Little-endian byte lanes.
//  BE: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
//  Load extract: byte lane addr[1:0]; half lane addr[1]; extend per sign_ext.
//  On fault: ack=1, fault=1, rdata=0, memory unchanged.
//  Back-to-back store then load to the same word: the load returns the new data.
//  Reset mid-access: abort; pending store is discarded; ack is not issued; re-enter reset state.
// TESTING
//  1. CLEAR_ON_RESET=1, DEPTH 2048, deassert reset -> busy high 2048 cycles, then init_done=1;
//     lw @0x0 -> 0x00000000.
//  2. sw 0x12345678 @0x10; sb 0x80 @0x11 -> lb @0x11 =0xFFFFFF80, lbu @0x11 =0x00000080,
//     lh @0x12 =0x00001234, lw @0x10 =0x12348078.
//  3. WAIT_CYCLES=3, load req at cycle T -> busy high T..T+3, ack exactly at T+4 only.
//  4. lw @0x6 -> ack+fault, rdata=0; sh @0x3 -> fault;
//     sw @ADDR_BASE+DEPTH_WORDS*4 -> fault, no array change.
//  5. sw 0xDEADBEEF @0x20 with kill raised in WAIT -> no ack, back to IDLE; lw @0x20 returns the prior value.
//  6. CLEAR_ON_RESET=0, reset during WAIT of sw 0xCAFEF00D @0x40 -> no ack; lw @0x40 returns the prior value.

Source files
------------

// File: rtl/dmem_ws_ctrl.sv
`default_nettype none
// dmem_ws_ctrl: M-stage data memory with req/ack handshake, programmable wait states,
// byte/half/word access with extension, fault reporting and post-reset clear.
module dmem_ws_ctrl #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          DEPTH_WORDS    = 2048,
  parameter int          WAIT_CYCLES    = 1,
  parameter int          CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        kill,
  output logic        busy,
  output logic        ack,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        init_done
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [AW-1:0] clr_idx;
  logic [31:0] mem [DEPTH_WORDS];

  logic        l_we, l_sx;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;

  logic        a_we, a_sx, a_fault, enter_resp, do_write;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, offset, rd_word, rd_shift, ext, wlane, wmask;
  logic [3:0]  be;
  logic [AW-1:0] widx;

  // In IDLE the access decodes straight from the ports so WAIT_CYCLES=0 works;
  // otherwise it uses the copy latched at acceptance.
  always_comb begin
    a_we    = (state == S_IDLE) ? we       : l_we;
    a_sx    = (state == S_IDLE) ? sign_ext : l_sx;
    a_size  = (state == S_IDLE) ? size     : l_size;
    a_addr  = (state == S_IDLE) ? addr     : l_addr;
    a_wdata = (state == S_IDLE) ? wdata    : l_wdata;
    offset  = a_addr - ADDR_BASE;
    widx    = offset[AW+1:2];
    a_fault = (a_size == 2'b11)
            | ((a_size == 2'b01) & a_addr[0])
            | ((a_size == 2'b10) & (a_addr[1:0] != 2'b00))
            | ({1'b0, offset} >= MEM_BYTES);

    be    = 4'b1111;
    wlane = a_wdata;
    case (a_size)
      2'b00: begin be = 4'b0001 << a_addr[1:0]; wlane = {4{a_wdata[7:0]}};  end
      2'b01: begin be = a_addr[1] ? 4'b1100 : 4'b0011; wlane = {2{a_wdata[15:0]}}; end
      default: ;
    endcase
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    rd_word  = mem[widx];
    rd_shift = rd_word >> {a_addr[1:0], 3'b000};
    case (a_size)
      2'b00:   ext = {{24{a_sx & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ext = a_addr[1] ? {{16{a_sx & rd_word[31]}}, rd_word[31:16]}
                               : {{16{a_sx & rd_word[15]}}, rd_word[15:0]};
      default: ext = rd_word;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: if (clr_idx == AW'(DEPTH_WORDS - 1)) state_nx = S_IDLE;
      S_IDLE:  if (req && !kill) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (kill) state_nx = S_IDLE;
               else if (cnt == 4'd1) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy       = (state == S_CLEAR) | (state == S_WAIT) | ((state == S_IDLE) & req & ~kill);
  assign enter_resp = (state_nx == S_RESP);
  assign do_write   = enter_resp & a_we & ~a_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_idx   <= '0;
      cnt       <= 4'd0;
      ack       <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'd0;
      init_done <= 1'b0;
      l_we      <= 1'b0;
      l_sx      <= 1'b0;
      l_size    <= 2'b00;
      l_addr    <= 32'd0;
      l_wdata   <= 32'd0;
    end else begin
      state <= state_nx;
      ack   <= enter_resp;
      fault <= enter_resp & a_fault;
      if (enter_resp) rdata <= (a_fault | a_we) ? 32'd0 : ext;
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (state_nx == S_IDLE) init_done <= 1'b1;
        end
        S_IDLE: begin
          init_done <= 1'b1;
          if (req && !kill) begin
            l_we    <= we;
            l_sx    <= sign_ext;
            l_size  <= size;
            l_addr  <= addr;
            l_wdata <= wdata;
            cnt     <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT:  cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Array has no reset of its own; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR)
        mem[clr_idx] <= 32'd0;
      else if (do_write)
        mem[widx] <= (rd_word & ~wmask) | (wlane & wmask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ws_ctrl.sv
`default_nettype none
// Directed self-checking bench for dmem_ws_ctrl: three instances covering the
// default configuration, a 3-wait-state memory, and a non-clearing offset memory.
module tb_dmem_ws_ctrl;

  logic        clk = 1'b0;
  logic        reset    [3];
  logic        req      [3];
  logic        we       [3];
  logic [1:0]  size     [3];
  logic        sign_ext [3];
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
  logic        kill     [3];
  logic        busy     [3];
  logic        ack      [3];
  logic        fault    [3];
  logic [31:0] rdata    [3];
  logic        init_done[3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_ws_ctrl #(.ADDR_BASE(32'h0), .DEPTH_WORDS(2048), .WAIT_CYCLES(1), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .size(size[0]), .sign_ext(sign_ext[0]),
    .addr(addr[0]), .wdata(wdata[0]), .kill(kill[0]), .busy(busy[0]), .ack(ack[0]),
    .fault(fault[0]), .rdata(rdata[0]), .init_done(init_done[0]));

  dmem_ws_ctrl #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .WAIT_CYCLES(3), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .size(size[1]), .sign_ext(sign_ext[1]),
    .addr(addr[1]), .wdata(wdata[1]), .kill(kill[1]), .busy(busy[1]), .ack(ack[1]),
    .fault(fault[1]), .rdata(rdata[1]), .init_done(init_done[1]));

  dmem_ws_ctrl #(.ADDR_BASE(32'h1000), .DEPTH_WORDS(64), .WAIT_CYCLES(1), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset(reset[2]), .req(req[2]), .we(we[2]), .size(size[2]), .sign_ext(sign_ext[2]),
    .addr(addr[2]), .wdata(wdata[2]), .kill(kill[2]), .busy(busy[2]), .ack(ack[2]),
    .fault(fault[2]), .rdata(rdata[2]), .init_done(init_done[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds req until ack (bounded); returns sampled outputs and cycles to ack.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output logic flt, output int lat);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; sign_ext[d] = sx; addr[d] = a; wdata[d] = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[d] && lat < 50);
    check({tag, "_ack"}, 32'(ack[d]), 32'd1);
    rd = rdata[d];
    flt = fault[d];
    req[d] = 1'b0;
  endtask

  task automatic ld(input int d, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input string tag, input logic [31:0] exp_d, input logic exp_f);
    logic [31:0] rd; logic flt; int lat;
    access(d, 1'b0, sz, sx, a, 32'd0, tag, rd, flt, lat);
    check({tag, "_data"}, rd, exp_d);
    check({tag, "_fault"}, 32'(flt), 32'(exp_f));
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                    input string tag, input logic exp_f);
    logic [31:0] rd; logic flt; int lat;
    access(d, 1'b1, sz, 1'b0, a, wd, tag, rd, flt, lat);
    check({tag, "_fault"}, 32'(flt), 32'(exp_f));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] rd;
    logic flt;
    int lat;
    for (int d = 0; d < 3; d++) begin
      reset[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'b00; sign_ext[d] = 1'b0;
      addr[d] = 32'd0; wdata[d] = 32'd0; kill[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", 32'(ack[0]), 32'd0);
    check("rst_fault", 32'(fault[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_init_done", 32'(init_done[0]), 32'd0);

    // Post-reset clear: 2048 busy cycles, then init_done.
    @(negedge clk);
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    #1;
    cnt = 0;
    while (busy[0] && cnt < 5000) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check("clear_busy_cycles", 32'(cnt), 32'd2048);
    check("clear_init_done", 32'(init_done[0]), 32'd1);

    access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, "lw0", rd, flt, lat);
    check("lw0_data", rd, 32'h0000_0000);
    check("lw0_latency", 32'(lat), 32'd2);

    // Byte merge and extension.
    st(0, 2'b10, 32'h10, 32'h1234_5678, "sw10", 1'b0);
    st(0, 2'b00, 32'h11, 32'h0000_0080, "sb11", 1'b0);
    ld(0, 2'b00, 1'b1, 32'h11, "lb11",  32'hFFFF_FF80, 1'b0);
    ld(0, 2'b00, 1'b0, 32'h11, "lbu11", 32'h0000_0080, 1'b0);
    ld(0, 2'b01, 1'b1, 32'h12, "lh12",  32'h0000_1234, 1'b0);
    ld(0, 2'b01, 1'b1, 32'h10, "lh10",  32'hFFFF_8078, 1'b0);
    ld(0, 2'b01, 1'b0, 32'h10, "lhu10", 32'h0000_8078, 1'b0);
    ld(0, 2'b10, 1'b0, 32'h10, "lw10",  32'h1234_8078, 1'b0);

    // Faults and range boundary.
    ld(0, 2'b10, 1'b0, 32'h6,  "lw6_misal", 32'h0, 1'b1);
    st(0, 2'b01, 32'h3, 32'hFFFF, "sh3_misal", 1'b1);
    st(0, 2'b10, 32'h2000, 32'hFFFF_FFFF, "sw_range", 1'b1);
    ld(0, 2'b10, 1'b0, 32'h0, "lw0_unchanged", 32'h0, 1'b0);
    ld(0, 2'b11, 1'b0, 32'h10, "size11", 32'h0, 1'b1);
    st(0, 2'b00, 32'h1FFF, 32'h0000_00A5, "sb_top", 1'b0);
    ld(0, 2'b00, 1'b0, 32'h1FFF, "lbu_top", 32'h0000_00A5, 1'b0);
    ld(0, 2'b10, 1'b0, 32'h1FFC, "lw_top",  32'hA500_0000, 1'b0);

    // Kill in IDLE: no acceptance.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; size[0] = 2'b10; addr[0] = 32'h10; kill[0] = 1'b1;
    #1;
    check("kill_idle_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    #1;
    check("kill_idle_ack", 32'(ack[0]), 32'd0);
    req[0] = 1'b0; kill[0] = 1'b0;

    // Kill in WAIT: store dropped.
    st(0, 2'b10, 32'h20, 32'h55AA_1234, "sw20_prior", 1'b0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'b10; addr[0] = 32'h20; wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    kill[0] = 1'b1;
    #1;
    check("kill_wait_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    req[0] = 1'b0; kill[0] = 1'b0;
    #1;
    check("kill_wait_ack0", 32'(ack[0]), 32'd0);
    check("kill_wait_idle", 32'(busy[0]), 32'd0);
    @(negedge clk);
    #1;
    check("kill_wait_ack1", 32'(ack[0]), 32'd0);
    ld(0, 2'b10, 1'b0, 32'h20, "lw20_after_kill", 32'h55AA_1234, 1'b0);

    // Three wait states: busy T..T+3, ack only at T+4.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'b10; addr[1] = 32'h4;
    #1;
    check("ws3_busy_T", 32'(busy[1]), 32'd1);
    check("ws3_ack_T", 32'(ack[1]), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("ws3_busy_T%0d", i), 32'(busy[1]), 32'd1);
      check($sformatf("ws3_ack_T%0d", i), 32'(ack[1]), 32'd0);
    end
    @(negedge clk);
    #1;
    check("ws3_ack_T4", 32'(ack[1]), 32'd1);
    check("ws3_busy_T4", 32'(busy[1]), 32'd0);
    check("ws3_rdata", rdata[1], 32'h0);
    req[1] = 1'b0;
    @(negedge clk);
    #1;
    check("ws3_ack_T5", 32'(ack[1]), 32'd0);

    // No-clear instance: init_done one cycle after reset, reset aborts a store.
    @(negedge clk);
    reset[2] = 1'b1;
    @(negedge clk);
    #1;
    check("nc_rst_init", 32'(init_done[2]), 32'd0);
    reset[2] = 1'b0;
    #1;
    check("nc_rel_init", 32'(init_done[2]), 32'd0);
    check("nc_rel_busy", 32'(busy[2]), 32'd0);
    @(negedge clk);
    #1;
    check("nc_init_done", 32'(init_done[2]), 32'd1);

    st(2, 2'b10, 32'h1040, 32'h1111_2222, "nc_sw_prior", 1'b0);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h1040; wdata[2] = 32'hCAFE_F00D;
    @(negedge clk);
    reset[2] = 1'b1;
    @(negedge clk);
    reset[2] = 1'b0; req[2] = 1'b0;
    #1;
    check("nc_abort_ack0", 32'(ack[2]), 32'd0);
    @(negedge clk);
    #1;
    check("nc_abort_ack1", 32'(ack[2]), 32'd0);
    ld(2, 2'b10, 1'b0, 32'h1040, "nc_lw_after_reset", 32'h1111_2222, 1'b0);
    ld(2, 2'b10, 1'b0, 32'h0FFC, "nc_below_base", 32'h0, 1'b1);
    ld(2, 2'b10, 1'b0, 32'h1100, "nc_above_top", 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
